voice_scheduler: RTL and testbench
==================================

// Module: voice_scheduler
// PURPOSE
//   Allocates incoming note-on/note-off requests onto NUM_VOICES tone voices.
//   Drives per-voice note index, active flag and 2-bit stereo code into the stereo conditioner.
//   Stereo code encoding: 01=R, 10=L, 11=both, 00=mute.
//   Holds each released voice for a fixed release time, then frees it.
//   Sits between the note sequencer (upstream) and the tone generators / stereo conditioner.
// PARAMETERS
//   NUM_VOICES     3     voice slots; the stereo conditioner takes 3
//   NOTE_W         7     note index width
//   RELEASE_TICKS  4800  sample ticks a voice stays in RELEASE (100 ms at 48 kHz)
//   AGE_W          8     saturating age counter width per voice
// PORTS
//   clk_in            in   1                  system clock
//   rst_in            in   1                  synchronous, active-high reset
//   sample_tick_in    in   1                  1-cycle pulse per audio sample (48 kHz)
//   req_valid_in      in   1                  request valid
//   req_ready_out     out  1                  request ready; transfer when valid&ready
//   req_on_in         in   1                  1 = note-on, 0 = note-off
//   req_note_in       in   NOTE_W             note index
//   req_pan_in        in   2                  stereo code for note-on
//   voice_note_out    out  NUM_VOICES*NOTE_W  per-voice note; voice 0 in LSBs
//   voice_stereo_out  out  2*NUM_VOICES       per-voice stereo code
//   voice_active_out  out  NUM_VOICES         1 while the voice is ACTIVE or RELEASE
//   steal_pulse_out   out  1                  1-cycle pulse when an occupied voice was stolen
// BEHAVIOUR
//   - Per-voice FSM: IDLE -> ACTIVE (note-on) -> RELEASE (note-off) -> IDLE (counter expired).
//     A note-on in RELEASE returns the voice to ACTIVE.
//   - Reset: all voices IDLE, all outputs 0, counters and ages 0. Reset mid-operation drops every voice at once.
//   - Latency: outputs are registered and reflect an accepted request on the next clk_in edge.
//   - Throughput: one request per cycle.
//   - Note-on, target selection in priority order:
//     (1) voice ACTIVE/RELEASE with the same note: retrigger, pan updated;
//     (2) lowest-index IDLE voice;
//     (3) full: steal per VOICE_STEAL_EN.
//     Target age <= 0. Every other occupied voice age += 1, saturating at 2^AGE_W-1.
//   - Note-off: lowest-index ACTIVE voice with a matching note -> RELEASE; counter <= RELEASE_TICKS.
//     No match: accepted, no effect.
//   - RELEASE: counter decrements on sample_tick_in. On a tick with counter==1 the voice goes IDLE.
//     Stereo/note held during RELEASE. IDLE forces stereo 00 and note 0.
//   - Same cycle, accepted request and sample_tick_in on the same voice: the request wins
//     (retrigger, or counter reload); the tick is ignored for that voice.
//   - Voices not touched by the request still count down on that tick.
//   - Pan is stored as given. A note-on with pan 00 allocates a muted voice (legal).
// CONFIGURATION
//   VOICE_STEAL_EN defined:
//     - req_ready_out = !rst_in.
//     - When full, steal the voice with the highest age, preferring RELEASE over ACTIVE; ties go to the lowest index.
//     - steal_pulse_out pulses on each steal.
//   VOICE_STEAL_EN undefined:
//     - req_ready_out = !rst_in & !(req_valid_in & req_on_in & no_idle & no_match), combinational from valid.
//     - The request stalls until a voice frees. steal_pulse_out is tied 0.
// STRUCTURE
//   - Shared header voice_sched_defs.vh:
//     - FSM state localparams VS_IDLE=2'd0, VS_ACTIVE=2'd1, VS_RELEASE=2'd2;
//     - stereo code localparams ST_MUTE/ST_R/ST_L/ST_LR;
//     - default RELEASE_TICKS.
//   - Sub-module voice_slot, instantiated NUM_VOICES times via generate. Holds the FSM, note, pan,
//     release counter and age; inputs: load_on, load_off, age_inc, tick.
//   - Top level holds match/idle search, steal selection and handshake.
// TESTING
//   1. Reset, then note-on 60/L, 64/R, 67/LR back-to-back ->
//      voices 0/1/2 = 60/10, 64/01, 67/11; active=3'b111; ready high throughout.
//   2. Note-off 64, then 4800 ticks ->
//      voice1 active until the 4800th tick, then active=0, stereo 00, note 0.
//   3. Full; note-on 72 with steal ->
//      voice0 (oldest) takes 72, steal_pulse 1 cycle.
//      Without steal: ready low until a voice frees, then accept.
//   4. Note-off 64 (voice1 RELEASE), 100 ticks later note-on 64/L ->
//      voice1 ACTIVE, stereo 10, no new voice used.
//   5. Accepted note-off coincident with sample_tick_in; note-off for an absent note 99 ->
//      counter loads 4800 exactly; note 99 accepted with no output change.
//   6. Assert rst_in mid-release with 3 voices busy ->
//      next cycle all outputs 0, ready 0 during reset, 1 after.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: per-voice states,
// stereo codes and default parameter values.
package voice_scheduler_pkg;

  typedef enum logic [1:0] {
    VS_IDLE    = 2'd0,
    VS_ACTIVE  = 2'd1,
    VS_RELEASE = 2'd2
  } vs_state_e;

  localparam logic [1:0] ST_MUTE = 2'b00;
  localparam logic [1:0] ST_R    = 2'b01;
  localparam logic [1:0] ST_L    = 2'b10;
  localparam logic [1:0] ST_LR   = 2'b11;

  localparam int unsigned DEF_NUM_VOICES    = 3;
  localparam int unsigned DEF_NOTE_W        = 7;
  localparam int unsigned DEF_RELEASE_TICKS = 4800;
  localparam int unsigned DEF_AGE_W         = 8;

endpackage

// File: rtl/voice_scheduler_if.sv
// Request / voice bus between the note sequencer, the voice scheduler
// and the tone generators / stereo conditioner.
interface voice_scheduler_if #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned NOTE_W     = 7
);
  logic                         sample_tick_in;
  logic                         req_valid_in;
  logic                         req_ready_out;
  logic                         req_on_in;
  logic [NOTE_W-1:0]            req_note_in;
  logic [1:0]                   req_pan_in;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note_out;
  logic [2*NUM_VOICES-1:0]      voice_stereo_out;
  logic [NUM_VOICES-1:0]        voice_active_out;
  logic                         steal_pulse_out;

  modport master (
    output sample_tick_in, req_valid_in, req_on_in, req_note_in, req_pan_in,
    input  req_ready_out, voice_note_out, voice_stereo_out, voice_active_out,
           steal_pulse_out
  );

  modport slave (
    input  sample_tick_in, req_valid_in, req_on_in, req_note_in, req_pan_in,
    output req_ready_out, voice_note_out, voice_stereo_out, voice_active_out,
           steal_pulse_out
  );
endinterface

// File: rtl/voice_scheduler_slot.sv
// One voice slot: IDLE/ACTIVE/RELEASE state, note, pan, release counter
// and saturating age. Loads from the request always beat the sample tick.
module voice_slot
  import voice_scheduler_pkg::*;
#(
  parameter int unsigned NOTE_W        = DEF_NOTE_W,
  parameter int unsigned AGE_W         = DEF_AGE_W,
  parameter int unsigned RELEASE_TICKS = DEF_RELEASE_TICKS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              load_on,
  input  logic              load_off,
  input  logic              age_inc,
  input  logic              tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [1:0]        pan_in,
  output vs_state_e         state,
  output logic [NOTE_W-1:0] note,
  output logic [1:0]        pan,
  output logic [AGE_W-1:0]  age
);
  localparam int unsigned      CNT_W    = $clog2(RELEASE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_TICKS);

  vs_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (state == VS_RELEASE) && tick && (cnt == CNT_W'(1)) &&
                  !load_on && !load_off;

  // Next-state: request loads first, then release expiry.
  always_comb begin
    state_nxt = state;
    if (load_on)       state_nxt = VS_ACTIVE;
    else if (load_off) state_nxt = VS_RELEASE;
    else if (expire)   state_nxt = VS_IDLE;
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= VS_IDLE;
    else        state <= state_nxt;
  end

  // Note/pan/counter/age; freeing a voice clears its note and pan to mute.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      note <= '0;
      pan  <= ST_MUTE;
      cnt  <= '0;
      age  <= '0;
    end else if (load_on) begin
      note <= note_in;
      pan  <= pan_in;
      age  <= '0;
    end else if (load_off) begin
      cnt <= CNT_LOAD;
    end else if (expire) begin
      note <= '0;
      pan  <= ST_MUTE;
      cnt  <= '0;
      age  <= '0;
    end else begin
      if ((state == VS_RELEASE) && tick) cnt <= cnt - 1'b1;
      if (age_inc && (age != '1))        age <= age + 1'b1;
    end
  end
endmodule

// File: rtl/voice_scheduler.sv
// Voice scheduler top: note-on/off allocation onto NUM_VOICES slots,
// retrigger on matching note, optional voice stealing.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when full
// (RELEASE preferred); otherwise a note-on stalls until a voice frees.
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = DEF_NUM_VOICES,
  parameter int unsigned NOTE_W        = DEF_NOTE_W,
  parameter int unsigned RELEASE_TICKS = DEF_RELEASE_TICKS,
  parameter int unsigned AGE_W         = DEF_AGE_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  voice_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  vs_state_e         state_q [NUM_VOICES];
  logic [NOTE_W-1:0] note_q  [NUM_VOICES];
  logic [1:0]        pan_q   [NUM_VOICES];
  logic [AGE_W-1:0]  age_q   [NUM_VOICES];

  logic [NUM_VOICES-1:0] occupied, match_occ, match_act;
  logic [NUM_VOICES-1:0] load_on, load_off, age_inc;
  logic [IDX_W-1:0]      match_idx, idle_idx, off_idx, steal_idx, target_idx;
  logic                  found_match, found_idle, found_off;
  logic [AGE_W:0]        best_key, key;
  logic                  ready, accept, steal_q;

  // Per-voice occupancy and note comparison against the request.
  always_comb begin
    occupied  = '0;
    match_occ = '0;
    match_act = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      occupied[i]  = (state_q[i] != VS_IDLE);
      match_occ[i] = occupied[i] && (note_q[i] == bus.req_note_in);
      match_act[i] = (state_q[i] == VS_ACTIVE) && (note_q[i] == bus.req_note_in);
    end
  end

  // Lowest-index searches for retrigger, free slot and note-off target.
  always_comb begin
    match_idx   = '0;
    idle_idx    = '0;
    off_idx     = '0;
    found_match = 1'b0;
    found_idle  = 1'b0;
    found_off   = 1'b0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found_match && match_occ[i]) begin
        found_match = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!found_idle && !occupied[i]) begin
        found_idle = 1'b1;
        idle_idx   = IDX_W'(i);
      end
      if (!found_off && match_act[i]) begin
        found_off = 1'b1;
        off_idx   = IDX_W'(i);
      end
    end
  end

  // Steal victim: key {in RELEASE, age}; strict compare keeps the lowest index on ties.
  always_comb begin
    steal_idx = '0;
    key       = '0;
    best_key  = {state_q[0] == VS_RELEASE, age_q[0]};
    for (int unsigned i = 1; i < NUM_VOICES; i++) begin
      key = {state_q[i] == VS_RELEASE, age_q[i]};
      if (key > best_key) begin
        best_key  = key;
        steal_idx = IDX_W'(i);
      end
    end
  end

  assign target_idx = found_match ? match_idx : (found_idle ? idle_idx : steal_idx);

`ifdef VOICE_STEAL_EN
  assign ready = !rst_in;
`else
  assign ready = !rst_in &&
                 !(bus.req_valid_in && bus.req_on_in && !found_idle && !found_match);
`endif

  assign accept = bus.req_valid_in && ready;

  // Per-voice load/age strobes for the accepted request.
  always_comb begin
    load_on  = '0;
    load_off = '0;
    age_inc  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (accept && bus.req_on_in) begin
        if (target_idx == IDX_W'(i)) load_on[i] = 1'b1;
        else if (occupied[i])        age_inc[i] = 1'b1;
      end
      if (accept && !bus.req_on_in && found_off && (off_idx == IDX_W'(i)))
        load_off[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot #(
      .NOTE_W       (NOTE_W),
      .AGE_W        (AGE_W),
      .RELEASE_TICKS(RELEASE_TICKS)
    ) u_slot (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .load_on (load_on[g]),
      .load_off(load_off[g]),
      .age_inc (age_inc[g]),
      .tick    (bus.sample_tick_in),
      .note_in (bus.req_note_in),
      .pan_in  (bus.req_pan_in),
      .state   (state_q[g]),
      .note    (note_q[g]),
      .pan     (pan_q[g]),
      .age     (age_q[g])
    );
  end

`ifdef VOICE_STEAL_EN
  // One-cycle pulse whenever a note-on had to take an occupied voice.
  always_ff @(posedge clk_in) begin
    if (rst_in) steal_q <= 1'b0;
    else        steal_q <= accept && bus.req_on_in && !found_match && !found_idle;
  end
`else
  assign steal_q = 1'b0;
`endif

  logic [NUM_VOICES*NOTE_W-1:0] note_bus;
  logic [2*NUM_VOICES-1:0]      stereo_bus;
  logic [NUM_VOICES-1:0]        active_bus;

  // Pack per-voice registers onto the output buses, voice 0 in the LSBs.
  always_comb begin
    note_bus   = '0;
    stereo_bus = '0;
    active_bus = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      note_bus[i*NOTE_W +: NOTE_W] = note_q[i];
      stereo_bus[2*i +: 2]         = pan_q[i];
      active_bus[i]                = occupied[i];
    end
  end

  assign bus.req_ready_out    = ready;
  assign bus.voice_note_out   = note_bus;
  assign bus.voice_stereo_out = stereo_bus;
  assign bus.voice_active_out = active_bus;
  assign bus.steal_pulse_out  = steal_q;
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler (covers both VOICE_STEAL_EN builds).
module tb_voice_scheduler;
  import voice_scheduler_pkg::*;

  localparam int unsigned NV = 3;
  localparam int unsigned NW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  voice_scheduler_if #(.NUM_VOICES(NV), .NOTE_W(NW)) bus ();

  voice_scheduler #(
    .NUM_VOICES   (NV),
    .NOTE_W       (NW),
    .RELEASE_TICKS(4800),
    .AGE_W        (8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nv(input logic [6:0] v0, input logic [6:0] v1,
                                     input logic [6:0] v2);
    return {11'd0, v2, v1, v0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic on, input logic [6:0] note, input logic [1:0] pan,
                      input logic tk);
    bus.req_valid_in   = 1'b1;
    bus.req_on_in      = on;
    bus.req_note_in    = note;
    bus.req_pan_in     = pan;
    bus.sample_tick_in = tk;
    #1;
    chk("ready_hi", 32'(bus.req_ready_out), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid_in   = 1'b0;
    bus.sample_tick_in = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_tick_in = 1'b1;
      cyc();
      bus.sample_tick_in = 1'b0;
      cyc();
    end
  endtask

  initial begin
    bus.sample_tick_in = 1'b0;
    bus.req_valid_in   = 1'b0;
    bus.req_on_in      = 1'b0;
    bus.req_note_in    = '0;
    bus.req_pan_in     = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_ready",  32'(bus.req_ready_out),    32'd0);
    chk("rst_active", 32'(bus.voice_active_out), 32'd0);
    chk("rst_note",   32'(bus.voice_note_out),   32'd0);
    chk("rst_stereo", 32'(bus.voice_stereo_out), 32'd0);
    chk("rst_steal",  32'(bus.steal_pulse_out),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready_out), 32'd1);

    // Three note-ons back-to-back fill voices 0/1/2
    send(1'b1, 7'd60, ST_L,  1'b0);
    send(1'b1, 7'd64, ST_R,  1'b0);
    send(1'b1, 7'd67, ST_LR, 1'b0);
    chk("t1_note",   32'(bus.voice_note_out),   nv(60, 64, 67));
    chk("t1_stereo", 32'(bus.voice_stereo_out), 32'b11_01_10);
    chk("t1_active", 32'(bus.voice_active_out), 32'b111);

    // Note-off for an absent note is accepted with no effect
    send(1'b0, 7'd99, ST_MUTE, 1'b0);
    chk("off99_note",   32'(bus.voice_note_out),   nv(60, 64, 67));
    chk("off99_stereo", 32'(bus.voice_stereo_out), 32'b11_01_10);
    chk("off99_active", 32'(bus.voice_active_out), 32'b111);

    // Note-off 64 together with a tick: counter must load the full 4800
    send(1'b0, 7'd64, ST_MUTE, 1'b1);
    chk("rel_active0", 32'(bus.voice_active_out), 32'b111);
    ticks(4799);
    chk("rel_active_4799", 32'(bus.voice_active_out), 32'b111);
    chk("rel_note_4799",   32'(bus.voice_note_out),   nv(60, 64, 67));
    chk("rel_stereo_4799", 32'(bus.voice_stereo_out), 32'b11_01_10);
    ticks(1);
    chk("rel_active_4800", 32'(bus.voice_active_out), 32'b101);
    chk("rel_note_4800",   32'(bus.voice_note_out),   nv(60, 0, 67));
    chk("rel_stereo_4800", 32'(bus.voice_stereo_out), 32'b11_00_10);

    // Refill voice 1; ages now v0=3, v1=0, v2=1
    send(1'b1, 7'd64, ST_R, 1'b0);
    chk("refill_active", 32'(bus.voice_active_out), 32'b111);
    chk("refill_note",   32'(bus.voice_note_out),   nv(60, 64, 67));

`ifdef VOICE_STEAL_EN
    // Full: oldest voice 0 is stolen
    send(1'b1, 7'd72, ST_L, 1'b0);
    chk("steal_pulse",  32'(bus.steal_pulse_out),  32'd1);
    chk("steal_note",   32'(bus.voice_note_out),   nv(72, 64, 67));
    chk("steal_stereo", 32'(bus.voice_stereo_out), 32'b11_01_10);
    cyc();
    chk("steal_pulse_end", 32'(bus.steal_pulse_out), 32'd0);
`else
    // Full: note-on stalls until the released voice 2 frees
    send(1'b0, 7'd67, ST_MUTE, 1'b0);
    bus.req_valid_in = 1'b1;
    bus.req_on_in    = 1'b1;
    bus.req_note_in  = 7'd72;
    bus.req_pan_in   = ST_L;
    #1;
    chk("stall_ready0", 32'(bus.req_ready_out), 32'd0);
    ticks(4799);
    chk("stall_ready_4799", 32'(bus.req_ready_out),  32'd0);
    chk("stall_note_4799",  32'(bus.voice_note_out), nv(60, 64, 67));
    bus.sample_tick_in = 1'b1;
    cyc();
    bus.sample_tick_in = 1'b0;
    chk("stall_freed_active", 32'(bus.voice_active_out), 32'b011);
    chk("stall_ready_freed",  32'(bus.req_ready_out),    32'd1);
    cyc();
    bus.req_valid_in = 1'b0;
    chk("stall_note",   32'(bus.voice_note_out),   nv(60, 64, 72));
    chk("stall_stereo", 32'(bus.voice_stereo_out), 32'b10_01_10);
    chk("stall_active", 32'(bus.voice_active_out), 32'b111);
    chk("nosteal_pulse", 32'(bus.steal_pulse_out), 32'd0);
`endif

    // Retrigger a releasing voice: voice 1 back to ACTIVE with new pan
    send(1'b0, 7'd64, ST_MUTE, 1'b0);
    ticks(100);
    send(1'b1, 7'd64, ST_L, 1'b0);
    chk("retrig_active", 32'(bus.voice_active_out), 32'b111);
    chk("retrig_pan1",   32'(bus.voice_stereo_out[3:2]), 32'b10);
    chk("retrig_note1",  32'(bus.voice_note_out[13:7]),  32'd64);
    ticks(10);
    chk("retrig_hold", 32'(bus.voice_active_out), 32'b111);

    // Reset mid-release with all voices busy
    send(1'b0, 7'd64, ST_MUTE, 1'b0);
    ticks(3);
    rst = 1'b1;
    cyc();
    chk("mrst_active", 32'(bus.voice_active_out), 32'd0);
    chk("mrst_note",   32'(bus.voice_note_out),   32'd0);
    chk("mrst_stereo", 32'(bus.voice_stereo_out), 32'd0);
    chk("mrst_steal",  32'(bus.steal_pulse_out),  32'd0);
    chk("mrst_ready",  32'(bus.req_ready_out),    32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(bus.req_ready_out), 32'd1);

    // Pan 00 allocates a muted but active voice
    send(1'b1, 7'd50, ST_MUTE, 1'b0);
    chk("mute_active", 32'(bus.voice_active_out), 32'b001);
    chk("mute_stereo", 32'(bus.voice_stereo_out), 32'd0);
    chk("mute_note",   32'(bus.voice_note_out),   nv(50, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
